// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit bus adapter: FSM states and RISC-V funct3 encodings.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: legality/misalign checks, store strobe and shift, load shift and extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                wen,
    input  logic [2:0]          funct3,
    input  logic [2:0]          addr_lo,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata,
    output logic                misalign_c,
    output logic                illegal_c,
    output logic [DATA_W/8-1:0] wstrb_c,
    output logic [DATA_W-1:0]   wdata_c,
    output logic [DATA_W-1:0]   rdata_c
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam bit          IS_64  = (DATA_W == 64);

    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] rsh;
    logic [7:0]        strb8;

    assign off     = addr_lo[OFF_W-1:0];
    assign wdata_c = wdata << {off, 3'b000};
    assign rsh     = rdata >> {off, 3'b000};
    assign wstrb_c = STRB_W'(strb8) << off;

    // Access size is funct3[1:0] for both loads and stores.
    always_comb begin
        strb8      = 8'h00;
        misalign_c = 1'b0;
        case (funct3[1:0])
            2'b00:   strb8 = 8'h01;
            2'b01:   begin strb8 = 8'h03; misalign_c = addr_lo[0];    end
            2'b10:   begin strb8 = 8'h0F; misalign_c = |addr_lo[1:0]; end
            default: begin strb8 = 8'hFF; misalign_c = |addr_lo;      end
        endcase
    end

    always_comb begin
        illegal_c = 1'b0;
        if (wen) begin
            illegal_c = funct3[2] || ((funct3[1:0] == 2'b11) && !IS_64);
        end else if ((funct3 == F3_LD) || (funct3 == F3_LWU)) begin
            illegal_c = !IS_64;
        end else begin
            illegal_c = (funct3 == 3'b111);
        end
    end

    always_comb begin
        rdata_c = rsh;
        case (funct3)
            F3_LB:   rdata_c = DATA_W'($signed(rsh[7:0]));
            F3_LH:   rdata_c = DATA_W'($signed(rsh[15:0]));
            F3_LW:   rdata_c = DATA_W'($signed(rsh[31:0]));
            F3_LBU:  rdata_c = DATA_W'(rsh[7:0]);
            F3_LHU:  rdata_c = DATA_W'(rsh[15:0]);
            F3_LWU:  rdata_c = DATA_W'(rsh[31:0]);
            default: rdata_c = rsh;
        endcase
    end

endmodule

// File: rtl/lsu_bus.sv
// Single-outstanding load/store adapter between a RISC-V LSU request port and a word-aligned memory bus.
module lsu_bus
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rerr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    lsu_state_e        state_q, state_d;
    logic              wen_q, wen_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2:0]        addr_lo_q, addr_lo_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              idle_c;
    logic              al_wen_c;
    logic [2:0]        al_funct3_c;
    logic [2:0]        al_addr_lo_c;
    logic              misalign_c, illegal_c;
    logic [STRB_W-1:0] al_wstrb_c;
    logic [DATA_W-1:0] al_wdata_c, al_rdata_c;

    // In IDLE the aligner sees the incoming request; afterwards it sees the latched one.
    assign idle_c       = (state_q == IDLE);
    assign al_wen_c     = idle_c ? req_wen         : wen_q;
    assign al_funct3_c  = idle_c ? req_funct3      : funct3_q;
    assign al_addr_lo_c = idle_c ? req_addr[2:0]   : addr_lo_q;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .wen        (al_wen_c),
        .funct3     (al_funct3_c),
        .addr_lo    (al_addr_lo_c),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .misalign_c (misalign_c),
        .illegal_c  (illegal_c),
        .wstrb_c    (al_wstrb_c),
        .wdata_c    (al_wdata_c),
        .rdata_c    (al_rdata_c)
    );

    always_comb begin
        state_d      = state_q;
        wen_d        = wen_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d     = req_wen;
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[2:0];
                    if (misalign_c || illegal_c) begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = REQ;
                        mem_we_d    = req_wen;
                        mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        mem_wdata_d = al_wdata_c;
                        mem_wstrb_d = req_wen ? al_wstrb_c : '0;
                    end
                end
            end
            REQ: begin
                if (mem_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d      = RESP;
                    resp_err_d   = mem_rerr;
                    resp_rdata_d = wen_q ? '0 : al_rdata_c;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d  = (state_d == IDLE);
        mem_valid_d  = (state_d == REQ);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wen_q        <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 3'b000;
            req_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: vector table on a 32-bit instance, hand sequences for stalls,
// reset mid-transaction and 64-bit lane handling.
module tb_lsu_bus;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid, mem_rerr;
    logic [31:0] mem_rdata;

    logic        w_req_valid, w_req_ready, w_req_wen;
    logic [2:0]  w_req_funct3;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic        w_resp_valid, w_resp_ready, w_resp_err;
    logic [63:0] w_resp_rdata;
    logic        w_mem_valid, w_mem_ready, w_mem_we;
    logic [31:0] w_mem_addr;
    logic [63:0] w_mem_wdata;
    logic [7:0]  w_mem_wstrb;
    logic        w_mem_rvalid, w_mem_rerr;
    logic [63:0] w_mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;

    lsu_bus #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr)
    );

    lsu_bus #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_wen(w_req_wen),
        .req_funct3(w_req_funct3), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .resp_valid(w_resp_valid), .resp_ready(w_resp_ready), .resp_rdata(w_resp_rdata), .resp_err(w_resp_err),
        .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
        .mem_wdata(w_mem_wdata), .mem_wstrb(w_mem_wstrb),
        .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata), .mem_rerr(w_mem_rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_valid && mem_ready) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        rerr;
        logic        issue;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input logic rerr,
                                input logic issue, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                input logic [3:0] e_strb, input logic e_err, input logic [31:0] e_rdata);
        vec_t v;
        v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rerr = rerr;
        v.issue = issue; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_strb = e_strb;
        v.e_err = e_err; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run64(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] rd, input logic [31:0] e_addr, input logic [63:0] e_rd);
        chk({nm, "_req_ready"}, w_req_ready, 1);
        w_req_valid = 1'b1; w_req_funct3 = f3; w_req_addr = addr;
        @(negedge clk);
        w_req_valid = 1'b0;
        chk({nm, "_mem_valid"}, w_mem_valid, 1);
        chk({nm, "_mem_addr"}, w_mem_addr, e_addr);
        chk({nm, "_mem_wstrb"}, w_mem_wstrb, 0);
        w_mem_ready = 1'b1;
        @(negedge clk);
        w_mem_ready = 1'b0; w_mem_rvalid = 1'b1; w_mem_rdata = rd;
        @(negedge clk);
        w_mem_rvalid = 1'b0;
        chk({nm, "_resp_valid"}, w_resp_valid, 1);
        chk({nm, "_resp_rdata"}, w_resp_rdata, e_rd);
        chk({nm, "_resp_err"}, w_resp_err, 0);
        w_resp_ready = 1'b1;
        @(negedge clk);
        w_resp_ready = 1'b0;
    endtask

    initial begin
        vec_t v;
        int   hs0;

        rst_n = 1'b0;
        req_valid = 0; req_wen = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        resp_ready = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_rerr = 0;
        w_req_valid = 0; w_req_wen = 0; w_req_funct3 = 0; w_req_addr = 0; w_req_wdata = 0;
        w_resp_ready = 0; w_mem_ready = 0; w_mem_rvalid = 0; w_mem_rdata = 0; w_mem_rerr = 0;

        vecs.push_back(mk(1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'hDEAD_BEEF, 0, 1, 32'h8000_0000, 32'hAB00_0000, 4'h8, 0, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0002, 32'h0, 32'h80FF_0000, 0, 1, 32'h0, 32'h0, 4'h0, 0, 32'hFFFF_80FF));
        vecs.push_back(mk(0, 3'b101, 32'h0000_0002, 32'h0, 32'h80FF_0000, 0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h0000_80FF));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0001, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0));
        vecs.push_back(mk(0, 3'b110, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0));
        vecs.push_back(mk(0, 3'b111, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0));
        vecs.push_back(mk(1, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 0, 1, 32'h0000_0100, 32'h1234_0000, 4'hC, 0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0, 1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h0000_0001, 32'h0, 32'h0000_8000, 0, 1, 32'h0, 32'h0, 4'h0, 0, 32'hFFFF_FF80));
        vecs.push_back(mk(0, 3'b100, 32'h0000_0003, 32'h0, 32'h7F00_0000, 0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h0000_007F));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0004, 32'h0, 32'h1234_5678, 1, 1, 32'h0000_0004, 32'h0, 4'h0, 1, 32'h1234_5678));
        vecs.push_back(mk(1, 3'b001, 32'h0000_0001, 32'h0000_FFFF, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0003, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0));

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table: accept, optional bus transfer with 1-cycle ready and next-cycle rvalid, response
        foreach (vecs[i]) begin
            v   = vecs[i];
            hs0 = hs_cnt;
            chk($sformatf("v%0d_req_ready_idle", i), req_ready, 1);
            req_valid = 1'b1; req_wen = v.wen; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("v%0d_req_ready_busy", i), req_ready, 0);
            if (v.issue) begin
                chk($sformatf("v%0d_mem_valid", i), mem_valid, 1);
                chk($sformatf("v%0d_mem_addr", i), mem_addr, v.e_addr);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.e_wdata);
                chk($sformatf("v%0d_mem_wstrb", i), mem_wstrb, v.e_strb);
                chk($sformatf("v%0d_mem_we", i), mem_we, v.wen);
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                chk($sformatf("v%0d_mem_valid_drop", i), mem_valid, 0);
                mem_rvalid = 1'b1; mem_rdata = v.rdata; mem_rerr = v.rerr;
                @(negedge clk);
                mem_rvalid = 1'b0; mem_rerr = 1'b0;
            end else begin
                chk($sformatf("v%0d_no_mem_valid", i), mem_valid, 0);
            end
            chk($sformatf("v%0d_resp_valid", i), resp_valid, 1);
            chk($sformatf("v%0d_resp_err", i), resp_err, v.e_err);
            chk($sformatf("v%0d_resp_rdata", i), resp_rdata, v.e_rdata);
            chk($sformatf("v%0d_bus_handshakes", i), 64'(hs_cnt - hs0), 64'(v.issue));
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            chk($sformatf("v%0d_resp_done", i), resp_valid, 0);
        end

        // 64-bit lanes: upper-word loads and doubleword passthrough
        run64("d64_lwu", 3'b110, 32'h0000_0004, 64'h89AB_CDEF_0000_0000, 32'h0, 64'h0000_0000_89AB_CDEF);
        run64("d64_lw",  3'b010, 32'h0000_0004, 64'h89AB_CDEF_0000_0000, 32'h0, 64'hFFFF_FFFF_89AB_CDEF);
        run64("d64_lb",  3'b000, 32'h0000_0007, 64'h89AB_CDEF_0000_0000, 32'h0, 64'hFFFF_FFFF_FFFF_FF89);
        run64("d64_ld",  3'b011, 32'h0000_0108, 64'h0123_4567_89AB_CDEF, 32'h0000_0108, 64'h0123_4567_89AB_CDEF);

        // Backpressure on both sides with new requests pending upstream
        hs0 = hs_cnt;
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0024; req_wdata = 32'h0;
        @(negedge clk);
        req_addr = 32'h0000_0099; req_funct3 = 3'b000; req_wen = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_mem_valid", k), mem_valid, 1);
            chk($sformatf("stall%0d_mem_addr", k), mem_addr, 32'h0000_0024);
            chk($sformatf("stall%0d_mem_we", k), mem_we, 0);
            chk($sformatf("stall%0d_mem_wstrb", k), mem_wstrb, 0);
            chk($sformatf("stall%0d_req_ready", k), req_ready, 0);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d_resp_valid", k), resp_valid, 1);
            chk($sformatf("hold%0d_resp_rdata", k), resp_rdata, 32'h1357_9BDF);
            chk($sformatf("hold%0d_resp_err", k), resp_err, 0);
            chk($sformatf("hold%0d_req_ready", k), req_ready, 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("stall_resp_done", resp_valid, 0);
        chk("stall_one_txn", 64'(hs_cnt - hs0), 1);

        // Reset while waiting for a store response, then a stale bus response
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0008; req_wdata = 32'h1111_2222;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("wait_mem_we", mem_we, 1);
        chk("wait_resp_valid", resp_valid, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 1);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_mem_valid", mem_valid, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_mem_wstrb", mem_wstrb, 0);
        chk("arst_resp_err", resp_err, 0);
        chk("arst_resp_rdata", resp_rdata, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_rerr = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rerr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("late%0d_resp_valid", k), resp_valid, 0);
            chk($sformatf("late%0d_req_ready", k), req_ready, 1);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_bus.md
LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data path width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port req_valid/req_ready, input/output, 1 bit each, the upstream request handshake.
REQ-006 SHALL have port req_wen, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits, the RISC-V load/store funct3.
REQ-008 SHALL have ports req_addr (ADDR_W) and req_wdata (DATA_W), inputs, byte address and unshifted store data.
REQ-009 SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_rdata (output, DATA_W) and resp_err (output, 1), the upstream response.
REQ-010 SHALL have ports mem_valid (output, 1) and mem_ready (input, 1), the bus request handshake.
REQ-011 SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_W, aligned to DATA_W/8), mem_wdata (output, DATA_W) and mem_wstrb (output, DATA_W/8), the bus request payload.
REQ-012 SHALL have ports mem_rvalid (input, 1), mem_rdata (input, DATA_W) and mem_rerr (input, 1), the bus response; the bus response has no backpressure.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT and RESP.
REQ-014 IDLE: req_ready=1; on req_valid, SHALL latch all req_* fields and go to REQ, or go to RESP with err=1 if the access is misaligned.
REQ-015 Misaligned means: halfword with addr[0]!=0, word with addr[1:0]!=0, or doubleword with addr[2:0]!=0; a misaligned access SHALL issue no bus request.
REQ-016 Illegal funct3 (doubleword or LWU when DATA_W=32, or any unused code) SHALL be reported as resp_err=1 with no bus request.
REQ-017 REQ: mem_valid=1 with stable payload until mem_ready; the handshake cycle SHALL go to WAIT.
REQ-018 mem_addr SHALL equal the latched address with its low log2(DATA_W/8) bits cleared.
REQ-019 mem_wdata SHALL equal wdata shifted left by 8*offset.
REQ-020 mem_wstrb SHALL be (1,3,0xF,0xFF for byte/half/word/double) shifted left by offset; loads SHALL drive wstrb=0.
REQ-021 WAIT: on mem_rvalid, SHALL capture the data and mem_rerr and go to RESP; the bus response SHALL be accepted only in WAIT and ignored otherwise.
REQ-022 Load data SHALL be mem_rdata shifted right by 8*offset, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to DATA_W; LD SHALL pass the data through.
REQ-023 Store responses SHALL return resp_rdata=0.
REQ-024 RESP: resp_valid=1 with stable data/err until resp_ready; the handshake cycle SHALL return to IDLE.
REQ-025 Minimum latency (req accept to resp_valid) SHALL be 3 cycles with mem_ready=1 and mem_rvalid the cycle after the handshake.
REQ-026 SHALL allow only one outstanding transaction; req_ready=0 outside IDLE.

Reset
REQ-027 Asserting rst_n=0 SHALL asynchronously force the FSM to IDLE.
REQ-028 During reset, outputs SHALL be: req_ready=1, resp_valid=0, mem_valid=0, mem_we=0, mem_wstrb=0, resp_err=0, resp_rdata=0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no response; a late mem_rvalid after reset SHALL be ignored.

Structure
REQ-030 Package lsu_pkg SHALL hold the state enum and the funct3 constants (LB..LWU, SB..SD).
REQ-031 Alignment logic (misalign check, strobe, shift, extend) SHALL be one combinational sub-module, lsu_align.

Verification
REQ-032 DATA_W=32 SB addr 0x80000003 wdata 0xAB: mem_addr=0x80000000, wstrb=0x8, wdata=0xAB000000; resp_err=0.
REQ-033 LH addr 0x2 with mem_rdata 0x80FF0000: resp_rdata=0xFFFF80FF; LHU gives 0x000080FF.
REQ-034 LW addr 0x1: resp_err=1 within 2 cycles; mem_valid never asserted.
REQ-035 mem_ready held low 5 cycles, then resp_ready low 3 cycles: payload and resp fields stable throughout; exactly one transaction.
REQ-036 DATA_W=64 LWU addr 0x4 with mem_rdata 0x89ABCDEF_00000000: resp_rdata=0x00000000_89ABCDEF; LD under DATA_W=32 gives resp_err=1.
REQ-037 rst_n pulsed low in WAIT: FSM returns to IDLE; a following mem_rvalid produces no resp_valid.
